// File: rtl/line_rasterizer.sv
// rtl/line_rasterizer.sv - Bresenham segment rasterizer with valid/ready pixel output.
// Optional off-screen clipping: define LINE_RASTERIZER_CLIP_EN.
module line_rasterizer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);

    localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t state;
    logic [X_WIDTH-1:0] xs, xe, cur_x;
    logic [Y_WIDTH-1:0] ys, ye, cur_y;
    logic signed [W-1:0] dx, dy, err;
    logic sx_neg, sy_neg;

    logic signed [W-1:0] ddx, ddy, adx, ady, err_nxt;
    logic signed [W:0]   e2, dx_e, dy_e;
    logic step_x, step_y, at_end, accept;
    logic [X_WIDTH-1:0] nx;
    logic [Y_WIDTH-1:0] ny;
    logic start_vis, next_vis;

    assign ready   = (state == IDLE) & ~start;
    assign pixel_x = cur_x;
    assign pixel_y = cur_y;

    // Endpoints are zero-extended into W signed bits so differences never overflow.
    assign ddx = $signed({{(W-X_WIDTH){1'b0}}, xe}) - $signed({{(W-X_WIDTH){1'b0}}, xs});
    assign ddy = $signed({{(W-Y_WIDTH){1'b0}}, ye}) - $signed({{(W-Y_WIDTH){1'b0}}, ys});
    assign adx = ddx[W-1] ? -ddx : ddx;
    assign ady = ddy[W-1] ? -ddy : ddy;

    assign e2     = {err, 1'b0};
    assign dx_e   = {dx[W-1], dx};
    assign dy_e   = {dy[W-1], dy};
    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);
    assign err_nxt = err + (step_x ? dy : {W{1'b0}}) + (step_y ? dx : {W{1'b0}});
    assign nx = step_x ? (sx_neg ? cur_x - X_ONE : cur_x + X_ONE) : cur_x;
    assign ny = step_y ? (sy_neg ? cur_y - Y_ONE : cur_y + Y_ONE) : cur_y;
    assign at_end = (cur_x == xe) && (cur_y == ye);

    // A pixel not presented (clipped) is consumed by the stepper on its own.
    assign accept = pixel_ready | ~pixel_valid;

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [X_WIDTH:0] HOR_LIM = HOR_ACTIVE_PIXELS[X_WIDTH:0];
    localparam logic [Y_WIDTH:0] VER_LIM = VER_ACTIVE_PIXELS[Y_WIDTH:0];
    assign start_vis = ({1'b0, xs} < HOR_LIM) && ({1'b0, ys} < VER_LIM);
    assign next_vis  = ({1'b0, nx} < HOR_LIM) && ({1'b0, ny} < VER_LIM);
`else
    assign start_vis = 1'b1;
    assign next_vis  = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pixel_valid <= 1'b0;
            cur_x       <= '0;
            cur_y       <= '0;
            xs          <= '0;
            ys          <= '0;
            xe          <= '0;
            ye          <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xs    <= x1;
                        ys    <= y1;
                        xe    <= x2;
                        ye    <= y2;
                        state <= INIT;
                    end
                end
                INIT: begin
                    dx          <= adx;
                    dy          <= -ady;
                    err         <= adx - ady;
                    sx_neg      <= ~(xs < xe);
                    sy_neg      <= ~(ys < ye);
                    cur_x       <= xs;
                    cur_y       <= ys;
                    pixel_valid <= start_vis;
                    state       <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        if (at_end) begin
                            pixel_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            err         <= err_nxt;
                            cur_x       <= nx;
                            cur_y       <= ny;
                            pixel_valid <= next_vis;
                        end
                    end
                end
                default: begin
                    pixel_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// tb/tb_line_rasterizer.sv - scoreboard bench for line_rasterizer against a Bresenham model.
module tb_line_rasterizer;

    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x1 = '0, x2 = '0;
    logic [YW-1:0] y1 = '0, y2 = '0;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_valid;
    logic          pixel_ready = 1'b1;

    line_rasterizer dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y;} pix_t;
    pix_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int got = 0;
    int rmode = 0;
    int phase = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit visible(int x, int y);
`ifdef LINE_RASTERIZER_CLIP_EN
        return (x < 640) && (y < 480);
`else
        return 1'b1;
`endif
    endfunction

    // Walks the segment as a stream of grid points and returns how many are written.
    function automatic int model_line(int ax, int ay, int bx, int by);
        int ddx, ddy, sx, sy, err, e2, x, y, n;
        ddx = (bx > ax) ? bx - ax : ax - bx;
        ddy = -((by > ay) ? by - ay : ay - by);
        sx = (ax < bx) ? 1 : -1;
        sy = (ay < by) ? 1 : -1;
        err = ddx + ddy;
        x = ax;
        y = ay;
        n = 0;
        for (int k = 0; k < 4096; k++) begin
            if (visible(x, y)) begin
                exp_q.push_back('{x, y});
                n++;
            end
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; x += sx; end
            if (e2 <= ddx) begin err += ddx; y += sy; end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: pixel_ready = 1'b1;
            1: pixel_ready = 1'($urandom_range(0, 1));
            default: begin
                pixel_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end
        endcase
    end

    bit held = 1'b0;
    int hx, hy;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && pixel_valid) begin
                chk("stall_x", int'(pixel_x), hx);
                chk("stall_y", int'(pixel_y), hy);
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pixel_x, pixel_y);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pixel_x", int'(pixel_x), e.x);
                    chk("pixel_y", int'(pixel_y), e.y);
                end
                got++;
                held = 1'b0;
            end else if (pixel_valid) begin
                held = 1'b1;
                hx = int'(pixel_x);
                hy = int'(pixel_y);
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic launch(int ax, int ay, int bx, int by);
        @(posedge clk);
        #1;
        x1 = XW'(ax); y1 = YW'(ay); x2 = XW'(bx); y2 = YW'(by);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_line(int ax, int ay, int bx, int by, bit mid_start);
        int n;
        bit done;
        got = 0;
        n = model_line(ax, ay, bx, by);
        launch(ax, ay, bx, by);
        done = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (ready) begin done = 1'b1; break; end
            if (mid_start && i == 3) begin
                x1 = XW'(50); y1 = YW'(50); x2 = XW'(60); y2 = YW'(60);
                start = 1'b1;
            end
            if (mid_start && i == 4) start = 1'b0;
        end
        chk("line_done", int'(done), 1);
        chk("pixel_count", got, n);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bit seen;
        #1;
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_x", int'(pixel_x), 0);
        chk("rst_y", int'(pixel_y), 0);
        chk("rst_ready", int'(ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Horizontal line: latency, back-to-back pixels, ready right after the last accept.
        rmode = 0;
        got = 0;
        n = model_line(0, 10, 3, 10);
        chk("model_len_h", n, 4);
        @(posedge clk);
        #1;
        x1 = 0; y1 = 10; x2 = 3; y2 = 10;
        start = 1'b1;
        @(negedge clk);
        chk("ready_during_start", int'(ready), 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("valid_init_cycle", int'(pixel_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_valid", int'(pixel_valid), 1);
        end
        @(negedge clk);
        chk("end_valid", int'(pixel_valid), 0);
        chk("end_ready", int'(ready), 1);
        chk("h_count", got, 4);

        run_line(5, 5, 2, 2, 1'b0);
        run_line(7, 7, 7, 7, 1'b0);
        chk("degenerate_count", got, 1);
        run_line(0, 0, 1, 3, 1'b0);

        rmode = 2;
        phase = 0;
        run_line(0, 0, 3, 0, 1'b1);
        repeat (6) @(negedge clk);
        chk("idle_after_ignored_start", int'(pixel_valid), 0);

        // Asynchronous reset in the middle of a line.
        rmode = 0;
        n = model_line(0, 0, 9, 0);
        launch(0, 0, 9, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pixel_valid && pixel_x == 1) begin seen = 1'b1; break; end
        end
        chk("reached_pixel2", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(pixel_valid), 0);
        chk("midrst_ready", int'(ready), 1);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        run_line(4, 3, 6, 3, 1'b0);

        run_line(0, 478, 0, 500, 1'b0);
`ifndef LINE_RASTERIZER_CLIP_EN
        chk("offscreen_count", got, 23);
`endif

        for (int t = 0; t < 30; t++) begin
            int ax, ay, bx, by;
            rmode = $urandom_range(0, 2);
            ax = $urandom_range(0, 1023);
            ay = $urandom_range(0, 511);
            if (t % 2 == 0) begin
                bx = $urandom_range(0, 1023);
                by = $urandom_range(0, 511);
            end else begin
                bx = (ax + $urandom_range(0, 40)) % 1024;
                by = (ay + 511 - $urandom_range(0, 40)) % 512;
            end
            run_line(ax, ay, bx, by, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
